irq_priority_controller: RTL and testbench
==========================================

Name: irq_priority_controller

Overview:
- Two-level interrupt controller that sequences interrupt service for the core.
- Collects peripheral interrupt lines (timer, UART RX, I2C, SPI, external pins) with per-source synchronisation and rising-edge capture.
- Qualifies pending sources with CSR enable and priority bits, then arbitrates one winner and presents it with a req/ack handshake.
- Tracks low/high/nested service state across iret. Sits between the peripherals, the control/status register file and the core's fetch redirect.

Parameters:
N_SRC, 8, number of interrupt sources (fixed bit-indexing below assumes 8)
ID_W, 3, width of the source index output

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
irq_src  in  8  raw interrupt lines, asynchronous to clk; a rising edge is the event
int_en  in  8  per-source enable from CSR
int_prio  in  8  per-source class from CSR, 1 = high, 0 = low
gie  in  1  global interrupt enable from CSR
pend_clr  in  8  write-1-to-clear pulses from a CSR write, one cycle wide
irq_ack  in  1  core accepts the current request
iret  in  1  core executes return-from-interrupt, one-cycle pulse
irq_req  out  1  interrupt request to core
irq_id  out  3  index of requested source, valid while irq_req = 1
irq_high  out  1  class of requested source, valid while irq_req = 1
pending  out  8  captured-but-unserviced flags, readable through CSR
svc_state  out  2  00 IDLE, 01 LOW, 10 HIGH, 11 NESTED (high over low)

Behaviour:
- Reset (rst_n low, asynchronous): synchroniser flops, pending, irq_req, irq_id, irq_high and svc_state all go to 0. State is IDLE. Reset asserted mid-request or mid-service discards everything.
- Capture:
  - Each irq_src bit passes through a 2-flop synchroniser plus one history flop.
  - An edge is sync2 & ~hist.
  - pending[i] sets on the 3rd rising clk edge after irq_src[i] goes high (input meets setup at edge 1).
  - A level held high produces only one event.
- Pending clear:
  - pending[i] clears on pend_clr[i], or on an accepted ack with irq_id = i.
  - If an edge on source i arrives in the same cycle as its clear, set wins and pending[i] stays 1.
- Qualification: elig = pending & int_en & {8{gie}}. elig_hi = elig & int_prio. elig_lo = elig & ~int_prio.
- Arbitration:
  - Any elig_hi wins over elig_lo.
  - Within a class, the lowest index wins.
  - Arbitration is combinational; irq_req, irq_id and irq_high are registered.
- Request raise: irq_req goes 1 at the next edge when irq_req = 0 and one of these holds:
  - svc_state = IDLE and elig != 0;
  - svc_state = LOW and elig_hi != 0.
  - No request is raised in HIGH or NESTED.
  - Total latency from irq_src rise to irq_req = 4 cycles.
- Freeze: while irq_req = 1, irq_id and irq_high hold their values. A higher-priority arrival does not replace the request before ack.
- Withdraw: if the frozen source leaves elig (pend_clr, int_en drop, gie drop) while irq_req = 1 and no ack arrives that cycle:
  - irq_req drops at the next edge;
  - svc_state is unchanged;
  - re-arbitration may re-raise irq_req in the following cycle.
- Ack:
  - irq_ack is accepted only when irq_req = 1; an ack with irq_req = 0 is ignored.
  - On accept: irq_req drops at the next edge and pending[irq_id] clears.
  - State transitions on accept:
    - IDLE -> LOW if irq_high = 0.
    - IDLE -> HIGH if irq_high = 1.
    - LOW -> NESTED; only a high request is possible in LOW.
  - irq_req may re-raise no earlier than 2 cycles after the ack cycle.
- Iret:
  - NESTED -> LOW; HIGH -> IDLE; LOW -> IDLE.
  - iret in IDLE is ignored.
  - Iret does not modify pending.
- Simultaneous iret and accepted ack: iret is applied first, then the ack transition from the resulting state. Examples:
  - LOW + iret + high ack -> HIGH.
  - IDLE + iret + low ack -> LOW.
- Changes to int_prio after ack do not alter svc_state.

Test Plan:
- Reset state: release rst_n with irq_src = 0 -> irq_req = 0, pending = 8'h00, svc_state = 00.
- Low-priority service:
  - Stimulus: gie = 1, int_en = 8'hFF, int_prio = 0, rise irq_src[2].
  - Required: pending = 8'h04 after 3 cycles; irq_req = 1, irq_id = 2, irq_high = 0 after 4 cycles.
  - After irq_ack: pending = 0, svc_state = 01. After iret: svc_state = 00.
- Nesting:
  - Stimulus: in LOW (servicing source 2), rise irq_src[6] with int_prio[6] = 1.
  - Required: irq_req = 1, irq_id = 6, irq_high = 1. After ack: svc_state = 11. After iret: 01. After iret again: 00.
- Arbitration and freeze:
  - Stimulus: sources 5 (low) and 3 (high) rise in the same cycle.
  - Required: irq_id = 3, irq_high = 1.
  - Then, with source 3's request outstanding, source 1 (high) rises -> irq_id stays 3 until ack; next request is id = 1.
- Withdraw and clear race:
  - Stimulus: with irq_req = 1 for id = 4, pulse pend_clr[4].
  - Required: irq_req = 0 next cycle, svc_state unchanged.
  - Separately, a new irq_src[4] edge in the ack cycle -> pending[4] remains 1.
- Blocking and mid-operation reset:
  - Stimulus: gie = 0 with pending = 8'h10.
  - Required: irq_req stays 0.
  - Then set gie = 1, and assert rst_n low in the cycle irq_req rises -> all outputs 0 immediately.

Source files
------------

// File: rtl/irq_priority_controller.sv
// Two-level interrupt controller: synchronises and edge-captures peripheral
// interrupt lines, qualifies them with CSR enables/priorities, arbitrates a
// single winner and tracks low/high/nested service state across iret.
module irq_priority_controller #(
  parameter int unsigned N_SRC = 8,
  parameter int unsigned ID_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [N_SRC-1:0] int_en,
  input  logic [N_SRC-1:0] int_prio,
  input  logic             gie,
  input  logic [N_SRC-1:0] pend_clr,
  input  logic             irq_ack,
  input  logic             iret,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  output logic             irq_high,
  output logic [N_SRC-1:0] pending,
  output logic [1:0]       svc_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOW    = 2'b01,
    HIGH   = 2'b10,
    NESTED = 2'b11
  } svc_t;

  svc_t             state_q;
  svc_t             state_d;
  svc_t             after_iret;

  logic [N_SRC-1:0] sync1;
  logic [N_SRC-1:0] sync2;
  logic [N_SRC-1:0] hist;
  logic [N_SRC-1:0] edge_det;
  logic [N_SRC-1:0] ack_mask;
  logic [N_SRC-1:0] pending_d;

  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] elig_hi;
  logic [N_SRC-1:0] elig_lo;
  logic [ID_W-1:0]  win_id;
  logic             win_high;

  logic             accept;
  logic             withdraw;
  logic             raise;
  logic             req_d;
  logic [ID_W-1:0]  id_d;
  logic             high_d;

  // Two-flop synchroniser plus history flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign edge_det = sync2 & ~hist;
  assign accept   = irq_ack & irq_req;
  assign ack_mask = accept ? (N_SRC'(1) << irq_id) : '0;

  // A fresh edge wins over a clear landing in the same cycle
  assign pending_d = (pending & ~(pend_clr | ack_mask)) | edge_det;

  // Pending flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_d;
    end
  end

  assign elig    = pending & int_en & {N_SRC{gie}};
  assign elig_hi = elig & int_prio;
  assign elig_lo = elig & ~int_prio;

  // Fixed-priority arbiter: high class first, lowest index within a class
  always_comb begin
    win_id   = '0;
    win_high = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig_lo[i]) win_id = ID_W'(i);
    end
    if (|elig_hi) begin
      win_high = 1'b1;
      for (int i = N_SRC - 1; i >= 0; i--) begin
        if (elig_hi[i]) win_id = ID_W'(i);
      end
    end
  end

  // Service state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next service state: iret is applied first, then an accepted ack
  always_comb begin
    after_iret = state_q;
    state_d    = state_q;
    if (iret) begin
      case (state_q)
        NESTED:    after_iret = LOW;
        HIGH, LOW: after_iret = IDLE;
        default:   after_iret = state_q;
      endcase
    end
    state_d = after_iret;
    if (accept) begin
      case (after_iret)
        IDLE:    state_d = irq_high ? HIGH : LOW;
        LOW:     state_d = NESTED;
        default: state_d = after_iret;
      endcase
    end
  end

  // Request next-value logic: raise, freeze, withdraw and ack
  always_comb begin
    req_d    = irq_req;
    id_d     = irq_id;
    high_d   = irq_high;
    // A pend_clr on the frozen source counts as leaving eligibility at once
    withdraw = irq_req & ~accept & (~elig[irq_id] | pend_clr[irq_id]);
    raise    = ((state_q == IDLE) && (|elig)) ||
               ((state_q == LOW)  && (|elig_hi));
    if (irq_req) begin
      if (accept || withdraw) req_d = 1'b0;
    end else if (raise) begin
      req_d  = 1'b1;
      id_d   = win_id;
      high_d = win_high;
    end
  end

  // Registered request outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_req  <= 1'b0;
      irq_id   <= '0;
      irq_high <= 1'b0;
    end else begin
      irq_req  <= req_d;
      irq_id   <= id_d;
      irq_high <= high_d;
    end
  end

  assign svc_state = state_q;

endmodule

// File: tb/tb_irq_priority_controller.sv
// Directed self-checking bench for irq_priority_controller.
module tb_irq_priority_controller;

  logic       clk;
  logic       rst_n;
  logic [7:0] irq_src;
  logic [7:0] int_en;
  logic [7:0] int_prio;
  logic       gie;
  logic [7:0] pend_clr;
  logic       irq_ack;
  logic       iret;
  logic       irq_req;
  logic [2:0] irq_id;
  logic       irq_high;
  logic [7:0] pending;
  logic [1:0] svc_state;

  int checks = 0;
  int errors = 0;

  irq_priority_controller #(.N_SRC(8), .ID_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_src   (irq_src),
    .int_en    (int_en),
    .int_prio  (int_prio),
    .gie       (gie),
    .pend_clr  (pend_clr),
    .irq_ack   (irq_ack),
    .iret      (iret),
    .irq_req   (irq_req),
    .irq_id    (irq_id),
    .irq_high  (irq_high),
    .pending   (pending),
    .svc_state (svc_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    irq_src  = 8'h00;
    int_en   = 8'h00;
    int_prio = 8'h00;
    gie      = 1'b0;
    pend_clr = 8'h00;
    irq_ack  = 1'b0;
    iret     = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Reset state
    check("rst_req",     8'(irq_req),   8'h00);
    check("rst_pending", pending,       8'h00);
    check("rst_state",   8'(svc_state), 8'h00);
    check("rst_id",      8'(irq_id),    8'h00);
    check("rst_high",    8'(irq_high),  8'h00);

    // Ack without a request is ignored
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("stray_ack_state", 8'(svc_state), 8'h00);

    // Low-priority service of source 2
    gie = 1'b1; int_en = 8'hFF; int_prio = 8'h00;
    irq_src = 8'h04;
    tick(3);
    check("low_pend_3cyc", pending,     8'h04);
    check("low_req_3cyc",  8'(irq_req), 8'h00);
    tick();
    check("low_req_4cyc",  8'(irq_req),  8'h01);
    check("low_id",        8'(irq_id),   8'h02);
    check("low_high",      8'(irq_high), 8'h00);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("low_ack_pend",  pending,       8'h00);
    check("low_ack_state", 8'(svc_state), 8'h01);
    check("low_ack_req",   8'(irq_req),   8'h00);

    // Nesting: high source 6 while servicing low source 2
    int_prio = 8'h40;
    irq_src  = 8'h44;
    tick(4);
    check("nest_req",  8'(irq_req),  8'h01);
    check("nest_id",   8'(irq_id),   8'h06);
    check("nest_high", 8'(irq_high), 8'h01);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("nest_state", 8'(svc_state), 8'h03);
    iret = 1'b1; tick(); iret = 1'b0;
    check("nest_iret1", 8'(svc_state), 8'h01);
    iret = 1'b1; tick(); iret = 1'b0;
    check("nest_iret2", 8'(svc_state), 8'h00);
    tick(2);
    check("level_once_req",  8'(irq_req), 8'h00);
    check("level_once_pend", pending,     8'h00);
    irq_src = 8'h00;
    tick(3);

    // Arbitration: 5 (low) and 3 (high) together, then 1 (high) during freeze
    int_prio = 8'h0A;
    irq_src  = 8'h28;
    tick(4);
    check("arb_req",  8'(irq_req),  8'h01);
    check("arb_id",   8'(irq_id),   8'h03);
    check("arb_high", 8'(irq_high), 8'h01);
    check("arb_pend", pending,      8'h28);
    irq_src = 8'h2A;
    tick(4);
    check("freeze_pend", pending,     8'h2A);
    check("freeze_id",   8'(irq_id),  8'h03);
    check("freeze_req",  8'(irq_req), 8'h01);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("arb_ack_state", 8'(svc_state), 8'h02);
    check("arb_ack_pend",  pending,       8'h22);
    iret = 1'b1; tick(); iret = 1'b0;
    check("arb_iret_state", 8'(svc_state), 8'h00);
    tick();
    check("next_req",  8'(irq_req),  8'h01);
    check("next_id",   8'(irq_id),   8'h01);
    check("next_high", 8'(irq_high), 8'h01);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    iret = 1'b1; tick(); iret = 1'b0;
    tick();
    check("third_id",   8'(irq_id),   8'h05);
    check("third_high", 8'(irq_high), 8'h00);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("third_state", 8'(svc_state), 8'h01);
    check("third_pend",  pending,       8'h00);
    iret = 1'b1; tick(); iret = 1'b0;
    irq_src  = 8'h00;
    int_prio = 8'h00;
    tick(3);

    // Withdraw via pend_clr
    irq_src = 8'h10;
    tick(4);
    check("wd_req_before", 8'(irq_req), 8'h01);
    check("wd_id",         8'(irq_id),  8'h04);
    pend_clr = 8'h10; tick(); pend_clr = 8'h00;
    check("wd_req_after", 8'(irq_req),   8'h00);
    check("wd_state",     8'(svc_state), 8'h00);
    check("wd_pend",      pending,       8'h00);

    // Clear race: new edge on source 4 during its ack cycle
    irq_src = 8'h00;
    tick(3);
    irq_src = 8'h10;
    tick(4);
    check("race_req", 8'(irq_req), 8'h01);
    irq_src = 8'h00;
    tick(3);
    irq_src = 8'h10;
    tick(2);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("race_pend",  pending,       8'h10);
    check("race_state", 8'(svc_state), 8'h01);
    check("race_req_dropped", 8'(irq_req), 8'h00);

    // Blocking with gie = 0
    gie  = 1'b0;
    iret = 1'b1; tick(); iret = 1'b0;
    check("blk_state", 8'(svc_state), 8'h00);
    tick(3);
    check("blk_req",  8'(irq_req), 8'h00);
    check("blk_pend", pending,     8'h10);

    // Mid-operation asynchronous reset in the cycle irq_req rises
    gie = 1'b1;
    tick();
    check("pre_rst_req", 8'(irq_req), 8'h01);
    check("pre_rst_id",  8'(irq_id),  8'h04);
    rst_n = 1'b0;
    #1;
    check("arst_req",   8'(irq_req),   8'h00);
    check("arst_id",    8'(irq_id),    8'h00);
    check("arst_high",  8'(irq_high),  8'h00);
    check("arst_pend",  pending,       8'h00);
    check("arst_state", 8'(svc_state), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
